// File: rtl/result_arbiter.sv
// result_arbiter: per-unit result FIFOs with round-robin grant onto the ex_mem_* bundle.
// Define RESULT_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins).
module result_arbiter #(
  parameter int NUM_FU = 3,
  parameter int DEPTH  = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_FU-1:0]                 fu_valid,
  output logic [NUM_FU-1:0]                 fu_ready,
  input  logic [5*NUM_FU-1:0]               fu_regdest,
  input  logic [NUM_FU-1:0]                 fu_writereg,
  input  logic [NUM_FU-1:0]                 fu_readmem,
  input  logic [NUM_FU-1:0]                 fu_writemem,
  input  logic [NUM_FU-1:0]                 fu_selwsource,
  input  logic [32*NUM_FU-1:0]              fu_wbvalue,
  input  logic [32*NUM_FU-1:0]              fu_regb,
  output logic                              ex_mem_readmem,
  output logic                              ex_mem_writemem,
  output logic                              ex_mem_selwsource,
  output logic [4:0]                        ex_mem_regdest,
  output logic                              ex_mem_writereg,
  output logic [31:0]                       ex_mem_wbvalue,
  output logic [31:0]                       ex_mem_regb,
  output logic                              ex_is_stall,
  output logic [$clog2(NUM_FU*DEPTH+1)-1:0] ex_pending
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int W    = 73;
  localparam int RW   = $clog2(NUM_FU);
  localparam int PEND = $clog2(NUM_FU*DEPTH+1);
  logic [W-1:0]    mem_q [NUM_FU][DEPTH];
  logic [W-1:0]    mem_d [NUM_FU][DEPTH];
  logic [PW-1:0]   wr_q [NUM_FU], wr_d [NUM_FU], rd_q [NUM_FU], rd_d [NUM_FU];
  logic [CW-1:0]   cnt_q [NUM_FU], cnt_d [NUM_FU];
  logic [W-1:0]    out_q, out_d;
  logic [PEND-1:0] pend_q, pend_d;
  logic [NUM_FU-1:0] full, push, pop;
  logic [RW-1:0]   g, idx;
  logic            found;
`ifdef RESULT_ARBITER_FIXED_PRIO_EN
`else
  logic [RW-1:0]   rr_q, rr_d;
`endif
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
`ifdef RESULT_ARBITER_FIXED_PRIO_EN
      idx = RW'(k);
`else
      idx = RW'((int'(rr_q) + k) % NUM_FU);
`endif
      if (!found && cnt_q[idx] != '0) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  always_comb begin
    mem_d = mem_q;
    pend_d = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      full[i] = cnt_q[i] == CW'(DEPTH);
      push[i] = fu_valid[i] & ~full[i];
      pop[i] = found && g == RW'(i);
      wr_d[i] = wr_q[i] + PW'(push[i]);
      rd_d[i] = rd_q[i] + PW'(pop[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (push[i])
        mem_d[i][wr_q[i]] = {fu_readmem[i], fu_writemem[i], fu_selwsource[i], fu_regdest[5*i +: 5],
                             fu_writereg[i], fu_wbvalue[32*i +: 32], fu_regb[32*i +: 32]};
      pend_d = pend_d + PEND'(cnt_d[i]);
    end
    out_d = found ? mem_q[g][rd_q[g]] : '0;
`ifdef RESULT_ARBITER_FIXED_PRIO_EN
`else
    rr_d = found ? RW'((int'(g) + 1) % NUM_FU) : rr_q;
`endif
  end
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_q <= '{default: '0};
      rd_q <= '{default: '0};
      cnt_q <= '{default: '0};
      out_q <= '0;
      pend_q <= '0;
`ifdef RESULT_ARBITER_FIXED_PRIO_EN
`else
      rr_q <= '0;
`endif
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      pend_q <= pend_d;
`ifdef RESULT_ARBITER_FIXED_PRIO_EN
`else
      rr_q <= rr_d;
`endif
    end
  end
  assign fu_ready = ~full;
  assign ex_is_stall = |full;
  assign ex_pending = pend_q;
  assign {ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_regdest,
          ex_mem_writereg, ex_mem_wbvalue, ex_mem_regb} = out_q;
endmodule
